uart_fifo_bridge: RTL and testbench
===================================

Name: uart_fifo_bridge

Overview:
- Sits between the CPU data bus and the uart register block, directly upstream of the uart.
- Adds a TX FIFO and an RX FIFO so byte writes do not stall the core for a full character time.
- Autonomously drains TX bytes into the uart data register.
- Polls the uart data register to fill the RX FIFO.
- Both sides use the same valid/ready/addr/wdata/wstrb/rdata bus; the uart itself is unchanged.

Parameters:
- TX_DEPTH, 16: TX FIFO entries; power of two, at least 2.
- RX_DEPTH, 16: RX FIFO entries; power of two, at least 2.
- POLL_GAP, 8: idle cycles between RX polls when no TX work is pending; 0 means back-to-back polls.

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- s_valid  in  1  CPU request
- s_ready  out  1  CPU request complete, one-cycle pulse
- s_addr  in  32  CPU address; only [7:0] decoded
- s_wdata  in  32  CPU write data
- s_wstrb  in  4  byte strobes; 0 means read
- s_rdata  out  32  CPU read data, valid when s_ready
- m_valid  out  1  request to uart
- m_ready  in  1  uart completion, combinational from uart
- m_addr  out  32  uart address: 0x04 DIV or 0x08 DAT
- m_wdata  out  32  uart write data
- m_wstrb  out  4  uart strobes
- m_rdata  in  32  uart read data
- irq  out  1  level interrupt

Behaviour:
- Reset is resetn, synchronous, active-low; clock is clk.
- Reset values: s_ready=0, s_rdata=0, m_valid=0, m_addr=0, m_wdata=0, m_wstrb=0, irq=0. Both FIFOs are empty, CTRL=0, FSM=IDLE, poll counter=0.
- Register map, CPU side, on s_addr[7:0]:
  - 0x00 STATUS, RO: [4:0] tx_count, [12:8] rx_count, [16] tx_full, [17] rx_empty, [18] rx_overflow (sticky; cleared by reading STATUS).
  - 0x04 DIV: forwarded unchanged to uart 0x04, read and write. s_ready is asserted in the cycle after the master transaction completes; s_rdata = captured m_rdata.
  - 0x08 DATA write: push s_wdata[7:0] when s_wstrb[0]=1.
    - TX not full: s_ready the next cycle.
    - TX full: s_ready stays low until an entry frees, then the push is done and s_ready is asserted. No data is dropped.
  - 0x08 DATA read:
    - RX non-empty: pop, s_rdata = {24'h0, byte}.
    - RX empty: s_rdata = 32'hFFFF_FFFF.
    - s_ready is asserted the next cycle in both cases; the read is never blocking.
  - 0x0C CTRL, RW:
    - [0] rx_poll_en
    - [1] irq_rx_en: irq when RX non-empty
    - [2] irq_tx_en: irq when TX empty
    - [8] tx_flush, self-clearing: empties TX
    - [9] rx_flush, self-clearing: empties RX
  - Other offsets: s_ready next cycle; reads return 0; writes are ignored.
- The slave accepts one request at a time. s_ready is a single-cycle pulse; s_valid is held until it.
- Master FSM states: IDLE, DIV_REQ, TX_REQ, RX_REQ, RESP.
  - m_valid is held with stable addr/wdata/wstrb until m_valid&&m_ready. The transaction completes that cycle and m_rdata is captured then.
  - IDLE priority:
    1. pending DIV access -> DIV_REQ
    2. TX non-empty -> TX_REQ: m_addr=0x08, wstrb=4'b0001, wdata={24'h0, head}. Pop at completion; a stall while the uart is busy is normal.
    3. rx_poll_en && RX not full && poll counter expired -> RX_REQ: m_addr=0x08, wstrb=0.
  - RX_REQ completion:
    - m_rdata[31]==0 -> push m_rdata[7:0] into RX.
    - Otherwise nothing is received.
    - Poll counter reloads with POLL_GAP.
  - An RX byte is only read when RX has space, so no uart byte is lost to the bridge. rx_overflow sets only if the uart had already overwritten data; it is not detectable, so in practice it sets on a push attempt to a full FIFO during flush races.
  - DIV_REQ completion -> RESP, which pulses s_ready -> IDLE.
- Simultaneous events:
  - CPU DATA read pop and RX_REQ push in the same cycle: count unchanged, both succeed.
  - CPU push and TX pop in the same cycle: count unchanged.
  - Flush concurrent with push: flush wins; the pushed byte is discarded.
- Pointers are log2(DEPTH) bits and wrap naturally. Counts are log2(DEPTH)+1 bits, zero-extended into the STATUS fields.
- Reset mid-transaction: m_valid drops the same cycle reset is sampled. No outstanding state survives.
- irq = (irq_rx_en && !rx_empty) || (irq_tx_en && tx_count==0), registered.

Decomposition:
- Package uart_bridge_pkg: register offsets (STATUS, DIV, DATA, CTRL), uart offsets (0x04, 0x08), FSM state enum, CTRL bit indices.
- One sub-module, sync_fifo (WIDTH, DEPTH), instantiated twice with WIDTH=8. Ports: push, pop, flush, din, dout (first-word visible), count, full, empty.

Test Plan:
- Write 0x41, 0x42, 0x43 to DATA with the uart model busy for 100 cycles per byte -> each s_ready within 2 cycles; m_wdata sequence 0x41, 0x42, 0x43 in order; tx_count reads 3, then 0.
- TX_DEPTH=16: 17 back-to-back DATA writes with the uart stalled -> the 17th s_ready is delayed until the first uart completion; all 17 bytes emitted in order.
- rx_poll_en=1; uart model returns 0x0000_005A once, else 0xFFFF_FFFF -> rx_count=1; DATA read gives 0x0000_005A; the next read gives 0xFFFF_FFFF.
- Write DIV=0x0000_00D9 -> m_addr 0x04 with wstrb 4'hF; readback gives 0xD9; s_ready only after the uart completes.
- RX full (16 entries) with the uart holding data -> no RX_REQ issued; pop one -> exactly one poll follows, and the byte is pushed.
- Assert resetn=0 during TX_REQ with m_valid high -> next cycle m_valid=0, counts=0, irq=0; no stale pop after release.

Source files
------------

// File: rtl/uart_bridge_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_bridge_pkg : offsets, CTRL bits and FSM states for the bridge |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package uart_bridge_pkg;

  localparam logic [7:0]  c_reg_status = 8'h00;
  localparam logic [7:0]  c_reg_div    = 8'h04;
  localparam logic [7:0]  c_reg_data   = 8'h08;
  localparam logic [7:0]  c_reg_ctrl   = 8'h0C;

  localparam logic [31:0] c_uart_div   = 32'h0000_0004;
  localparam logic [31:0] c_uart_dat   = 32'h0000_0008;

  localparam int c_ctrl_rx_poll_en = 0;
  localparam int c_ctrl_irq_rx_en  = 1;
  localparam int c_ctrl_irq_tx_en  = 2;
  localparam int c_ctrl_tx_flush   = 8;
  localparam int c_ctrl_rx_flush   = 9;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DIV_REQ = 3'd1,
    ST_TX_REQ  = 3'd2,
    ST_RX_REQ  = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_fifo_bridge_sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sync_fifo : single-clock FIFO, first word visible on dout, flush   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int                c_aw         = $clog2(DEPTH);
  localparam logic [c_aw:0]     c_full_count = (c_aw+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_aw:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // A push into a full FIFO is still legal when the head leaves in the same cycle
  assign w_pop  = pop && (r_count != '0);
  assign w_push = push && ((r_count != c_full_count) || w_pop);

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign count = r_count;
  assign full  = (r_count == c_full_count);
  assign empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/uart_fifo_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_fifo_bridge : CPU-side TX/RX FIFOs in front of the uart regs  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module uart_fifo_bridge
  import uart_bridge_pkg::*;
#(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16,
  parameter int POLL_GAP = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_addr,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  output logic [31:0] s_rdata,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic [31:0] m_rdata,
  output logic        irq
);

  localparam int              c_tx_aw       = $clog2(TX_DEPTH);
  localparam int              c_rx_aw       = $clog2(RX_DEPTH);
  localparam int              c_pw          = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;
  localparam logic [c_pw-1:0] c_poll_reload = c_pw'(POLL_GAP);

  state_t            r_state;
  logic [2:0]        r_ctrl;
  logic              r_div_pend;
  logic [31:0]       r_div_wdata;
  logic [3:0]        r_div_wstrb;
  logic              r_rx_ovf;
  logic              r_tx_stale;
  logic [c_pw-1:0]   r_poll_cnt;

  logic [c_tx_aw:0]  w_tx_count;
  logic [c_rx_aw:0]  w_rx_count;
  logic [7:0]        w_tx_dout;
  logic [7:0]        w_rx_dout;
  logic              w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic              w_req, w_is_wr, w_m_done;
  logic              w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
  logic              w_ctrl_wr, w_tx_flush, w_rx_flush;
  logic [7:0]        w_reg;
  logic [31:0]       w_status;
  logic              w_unused;

  // A request is taken once; the cycle s_ready is high and any DIV in flight block re-decode
  assign w_req      = s_valid && !s_ready && !r_div_pend;
  assign w_reg      = s_addr[7:0];
  assign w_is_wr    = |s_wstrb;
  assign w_m_done   = m_valid && m_ready;

  assign w_tx_push  = w_req && (w_reg == c_reg_data) && s_wstrb[0] && !w_tx_full;
  assign w_rx_pop   = w_req && (w_reg == c_reg_data) && !w_is_wr;
  assign w_ctrl_wr  = w_req && (w_reg == c_reg_ctrl) && w_is_wr;
  assign w_tx_flush = w_ctrl_wr && s_wdata[c_ctrl_tx_flush];
  assign w_rx_flush = w_ctrl_wr && s_wdata[c_ctrl_rx_flush];
  assign w_tx_pop   = w_m_done && (r_state == ST_TX_REQ) && !r_tx_stale;
  assign w_rx_push  = w_m_done && (r_state == ST_RX_REQ) && !m_rdata[31];

  assign w_status = {13'h0, r_rx_ovf, w_rx_empty, w_tx_full,
                     3'h0, 5'(w_rx_count), 3'h0, 5'(w_tx_count)};
  assign w_unused = &{1'b0, s_addr[31:8]};

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .resetn(resetn), .push(w_tx_push), .pop(w_tx_pop), .flush(w_tx_flush),
    .din(s_wdata[7:0]), .dout(w_tx_dout), .count(w_tx_count),
    .full(w_tx_full), .empty(w_tx_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .resetn(resetn), .push(w_rx_push), .pop(w_rx_pop), .flush(w_rx_flush),
    .din(m_rdata[7:0]), .dout(w_rx_dout), .count(w_rx_count),
    .full(w_rx_full), .empty(w_rx_empty)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s_ready     <= 1'b0;
      s_rdata     <= '0;
      m_valid     <= 1'b0;
      m_addr      <= '0;
      m_wdata     <= '0;
      m_wstrb     <= '0;
      irq         <= 1'b0;
      r_state     <= ST_IDLE;
      r_ctrl      <= '0;
      r_div_pend  <= 1'b0;
      r_div_wdata <= '0;
      r_div_wstrb <= '0;
      r_rx_ovf    <= 1'b0;
      r_tx_stale  <= 1'b0;
      r_poll_cnt  <= '0;
    end else begin
      s_ready <= 1'b0;
      irq     <= (r_ctrl[c_ctrl_irq_rx_en] && !w_rx_empty) ||
                 (r_ctrl[c_ctrl_irq_tx_en] && (w_tx_count == '0));

      if (w_req) begin
        case (w_reg)
          c_reg_status: begin
            s_ready <= 1'b1;
            s_rdata <= w_is_wr ? 32'h0 : w_status;
            if (!w_is_wr) r_rx_ovf <= 1'b0;
          end
          c_reg_div: begin
            r_div_pend  <= 1'b1;
            r_div_wdata <= s_wdata;
            r_div_wstrb <= s_wstrb;
          end
          c_reg_data: begin
            if (!w_is_wr) begin
              s_ready <= 1'b1;
              s_rdata <= w_rx_empty ? 32'hFFFF_FFFF : {24'h0, w_rx_dout};
            end else if (!s_wstrb[0] || !w_tx_full) begin
              s_ready <= 1'b1;
              s_rdata <= '0;
            end
          end
          c_reg_ctrl: begin
            s_ready <= 1'b1;
            s_rdata <= w_is_wr ? 32'h0 : {29'h0, r_ctrl};
            if (w_is_wr) r_ctrl <= s_wdata[2:0];
          end
          default: begin
            s_ready <= 1'b1;
            s_rdata <= '0;
          end
        endcase
      end

      // The byte already on m_wdata was flushed; its completion must not pop a newer entry
      if (w_tx_flush && (r_state == ST_TX_REQ)) r_tx_stale <= 1'b1;
      if (w_rx_push && w_rx_full && !w_rx_pop)   r_rx_ovf   <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (r_div_pend) begin
            m_valid <= 1'b1;
            m_addr  <= c_uart_div;
            m_wdata <= r_div_wdata;
            m_wstrb <= r_div_wstrb;
            r_state <= ST_DIV_REQ;
          end else if (!w_tx_empty) begin
            m_valid    <= 1'b1;
            m_addr     <= c_uart_dat;
            m_wdata    <= {24'h0, w_tx_dout};
            m_wstrb    <= 4'b0001;
            r_tx_stale <= 1'b0;
            r_state    <= ST_TX_REQ;
          end else if (r_ctrl[c_ctrl_rx_poll_en] && !w_rx_full && (r_poll_cnt == '0)) begin
            m_valid <= 1'b1;
            m_addr  <= c_uart_dat;
            m_wdata <= '0;
            m_wstrb <= '0;
            r_state <= ST_RX_REQ;
          end else if (r_poll_cnt != '0) begin
            r_poll_cnt <= r_poll_cnt - 1'b1;
          end
        end
        ST_DIV_REQ: begin
          if (w_m_done) begin
            m_valid    <= 1'b0;
            s_ready    <= 1'b1;
            s_rdata    <= m_rdata;
            r_div_pend <= 1'b0;
            r_state    <= ST_RESP;
          end
        end
        ST_TX_REQ: begin
          if (w_m_done) begin
            m_valid <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_RX_REQ: begin
          if (w_m_done) begin
            m_valid    <= 1'b0;
            r_poll_cnt <= c_poll_reload;
            r_state    <= ST_IDLE;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_uart_fifo_bridge : directed/random bench with a uart model      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_uart_fifo_bridge;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_addr = '0;
  logic [31:0] s_wdata = '0;
  logic [3:0]  s_wstrb = '0;
  logic [31:0] s_rdata;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  uart_fifo_bridge #(.TX_DEPTH(16), .RX_DEPTH(16), .POLL_GAP(8)) dut (
    .clk(clk), .resetn(resetn),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_rdata(s_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_rdata(m_rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  // uart model: each access stalls 'busy' cycles; received bytes come from uart_rx_mem
  int          busy = 0;
  int          uart_wait = 0;
  logic [31:0] uart_div = '0;
  logic [31:0] div_addr_seen = '0;
  logic [3:0]  div_wstrb_seen = '0;
  logic [7:0]  tx_log[$];
  int          polls = 0;
  logic [7:0]  uart_rx_mem[64];
  int          uart_rx_n = 0;
  int          uart_rx_rd = 0;

  assign m_ready = m_valid && (uart_wait == 0);

  always_comb begin
    m_rdata = 32'hFFFF_FFFF;
    if (m_addr[7:0] == 8'h04) m_rdata = uart_div;
    else if (uart_rx_rd < uart_rx_n) m_rdata = {24'h0, uart_rx_mem[uart_rx_rd]};
  end

  always @(posedge clk) begin
    if (!m_valid) begin
      uart_wait <= busy;
    end else if (m_ready) begin
      uart_wait <= busy;
      if (m_addr[7:0] == 8'h04) begin
        div_addr_seen <= m_addr;
        if (m_wstrb != 4'h0) begin
          uart_div       <= m_wdata;
          div_wstrb_seen <= m_wstrb;
        end
      end else if (m_wstrb != 4'h0) begin
        tx_log.push_back(m_wdata[7:0]);
      end else begin
        polls <= polls + 1;
        if (uart_rx_rd < uart_rx_n) uart_rx_rd <= uart_rx_rd + 1;
      end
    end else begin
      uart_wait <= uart_wait - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // STATUS as the register map describes it, from FIFO occupancies
  function automatic logic [31:0] status_exp(input int txc, input int rxc);
    return {13'h0, 1'b0, 1'(rxc == 0), 1'(txc == 16), 3'h0, 5'(rxc), 3'h0, 5'(txc)};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic cpu(input logic [7:0] a, input logic [31:0] wd, input logic [3:0] ws,
                     output logic [31:0] rd, output int cyc);
    s_addr = {24'h0, a}; s_wdata = wd; s_wstrb = ws; s_valid = 1'b1; cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (!s_ready && cyc < 5000);
    rd = s_rdata;
    check("s_ready_timeout", s_ready, 1'b1);
    @(posedge clk); #1;
    s_valid = 1'b0; s_wstrb = '0;
  endtask

  task automatic wait_tx(input int n);
    int k = 0;
    while (tx_log.size() < n && k < 4000) begin @(posedge clk); #1; k++; end
    check("tx_drain_timeout", 32'(tx_log.size() >= n), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    int          lat;
    int          base;
    int          n;
    int          p0;
    int          rx0;
    logic [7:0]  bytes[$];

    tick(3);
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_addr", m_addr, 32'h0);
    check("rst_s_rdata", s_rdata, 32'h0);
    check("rst_irq", irq, 1'b0);
    resetn = 1'b1;
    tick(1);
    cpu(8'h00, 0, 4'h0, rd, lat);
    check("rst_status", rd, status_exp(0, 0));

    // Three bytes into a slow uart
    busy = 100;
    base = tx_log.size();
    bytes = '{8'h41, 8'h42, 8'h43};
    foreach (bytes[i]) begin
      cpu(8'h08, {24'h0, bytes[i]}, 4'h1, rd, lat);
      check("tx3_latency_le2", 32'(lat <= 2), 32'd1);
    end
    cpu(8'h00, 0, 4'h0, rd, lat);
    check("tx3_count3", rd, status_exp(3, 0));
    wait_tx(base + 3);
    foreach (bytes[i]) check("tx3_order", tx_log[base + i], bytes[i]);
    tick(4);
    cpu(8'h00, 0, 4'h0, rd, lat);
    check("tx3_count0", rd, status_exp(0, 0));

    // 17 random bytes: the 17th waits for the first uart completion
    base = tx_log.size();
    bytes = {};
    for (int i = 0; i < 17; i++) begin
      bytes.push_back(8'($urandom));
      cpu(8'h08, {24'h0, bytes[i]}, 4'h1, rd, lat);
      if (i < 16) check("tx17_fast", 32'(lat <= 2), 32'd1);
      else        check("tx17_stalled", 32'(lat > 20), 32'd1);
    end
    wait_tx(base + 17);
    foreach (bytes[i]) check("tx17_order", tx_log[base + i], bytes[i]);

    // DIV passthrough
    busy = 20;
    cpu(8'h04, 32'h0000_00D9, 4'hF, rd, lat);
    check("div_wait_uart", 32'(lat > 20), 32'd1);
    check("div_addr", div_addr_seen, 32'h4);
    check("div_wstrb", div_wstrb_seen, 4'hF);
    check("div_value", uart_div, 32'hD9);
    cpu(8'h04, 0, 4'h0, rd, lat);
    check("div_readback", rd, 32'hD9);

    // Single RX byte then empty
    busy = 0;
    uart_rx_mem[uart_rx_n] = 8'h5A;
    uart_rx_n = uart_rx_n + 1;
    cpu(8'h0C, 32'h1, 4'hF, rd, lat);
    tick(40);
    cpu(8'h00, 0, 4'h0, rd, lat);
    check("rx1_count", rd, status_exp(0, 1));
    cpu(8'h08, 0, 4'h0, rd, lat);
    check("rx1_data", rd, 32'h5A);
    cpu(8'h08, 0, 4'h0, rd, lat);
    check("rx1_empty", rd, 32'hFFFF_FFFF);

    // Random RX burst with irq_rx_en
    cpu(8'h0C, 32'h3, 4'hF, rd, lat);
    n = $urandom_range(3, 10);
    bytes = {};
    for (int i = 0; i < n; i++) begin
      bytes.push_back(8'($urandom));
      uart_rx_mem[uart_rx_n + i] = bytes[i];
    end
    uart_rx_n = uart_rx_n + n;
    tick(12 * n + 30);
    check("rxn_irq_high", irq, 1'b1);
    cpu(8'h00, 0, 4'h0, rd, lat);
    check("rxn_count", rd, status_exp(0, n));
    foreach (bytes[i]) begin
      cpu(8'h08, 0, 4'h0, rd, lat);
      check("rxn_data", rd, {24'h0, bytes[i]});
    end
    cpu(8'h08, 0, 4'h0, rd, lat);
    check("rxn_empty", rd, 32'hFFFF_FFFF);
    tick(3);
    check("rxn_irq_low", irq, 1'b0);

    // RX full: no polls while full, exactly one after a pop
    cpu(8'h0C, 32'h1, 4'hF, rd, lat);
    rx0 = uart_rx_rd;
    bytes = {};
    for (int i = 0; i < 20; i++) begin
      bytes.push_back(8'($urandom));
      uart_rx_mem[uart_rx_n + i] = bytes[i];
    end
    uart_rx_n = uart_rx_n + 20;
    tick(300);
    cpu(8'h00, 0, 4'h0, rd, lat);
    check("rxfull_status", rd, status_exp(0, 16));
    check("rxfull_taken", uart_rx_rd - rx0, 32'd16);
    p0 = polls;
    tick(60);
    check("rxfull_no_poll", polls, p0);
    cpu(8'h08, 0, 4'h0, rd, lat);
    check("rxfull_pop", rd, {24'h0, bytes[0]});
    tick(60);
    check("rxfull_one_poll", polls, p0 + 1);
    check("rxfull_taken2", uart_rx_rd - rx0, 32'd17);
    cpu(8'h0C, 32'h0, 4'hF, rd, lat);
    for (int i = 1; i < 17; i++) begin
      cpu(8'h08, 0, 4'h0, rd, lat);
      check("rxfull_drain", rd, {24'h0, bytes[i]});
    end
    cpu(8'h08, 0, 4'h0, rd, lat);
    check("rxfull_empty", rd, 32'hFFFF_FFFF);

    // TX flush with one byte already on the uart bus
    busy = 100;
    base = tx_log.size();
    bytes = {};
    for (int i = 0; i < 4; i++) begin
      bytes.push_back(8'($urandom));
      cpu(8'h08, {24'h0, bytes[i]}, 4'h1, rd, lat);
    end
    cpu(8'h0C, 32'h100, 4'hF, rd, lat);
    cpu(8'h00, 0, 4'h0, rd, lat);
    check("flush_count0", rd, status_exp(0, 0));
    tick(150);
    check("flush_emitted", tx_log.size() - base, 32'd1);
    check("flush_head", tx_log[base], bytes[0]);

    // Reset during TX_REQ
    cpu(8'h0C, 32'h4, 4'hF, rd, lat);
    tick(2);
    check("irq_tx_empty", irq, 1'b1);
    cpu(8'h08, 32'h77, 4'h1, rd, lat);
    n = 0;
    while (!m_valid && n < 20) begin tick(1); n++; end
    check("pre_rst_m_valid", m_valid, 1'b1);
    resetn = 1'b0;
    tick(1);
    check("midrst_m_valid", m_valid, 1'b0);
    check("midrst_irq", irq, 1'b0);
    tick(1);
    resetn = 1'b1;
    base = tx_log.size();
    cpu(8'h00, 0, 4'h0, rd, lat);
    check("post_rst_status", rd, status_exp(0, 0));
    tick(150);
    check("post_rst_no_tx", tx_log.size(), base);
    check("post_rst_m_valid", m_valid, 1'b0);
    check("post_rst_irq", irq, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
